s8254_seq: RTL and testbench
============================

S8254_SEQ -- requirements
Module: s8254_seq

Interface
REQ-001 SHALL have parameter STROBE_CYC, default 2: width of the IOR_N/IOW_N low pulse in clk cycles, legal range 1..15.
REQ-002 SHALL have port clk  in  1  system clock; every flop is clocked on the rising edge.
REQ-003 SHALL have port RST_N  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports cmd_valid in 1 and cmd_ready out 1: command handshake.
REQ-005 SHALL have port cmd_op  in  2  command: 00 PROGRAM, 01 LATCH_READ, 10 READBACK, 11 reserved.
REQ-006 SHALL have ports cmd_mode in 3, cmd_rw in 2 and cmd_bcd in 1: counter-0 mode, RW field and BCD flag, used by PROGRAM only.
REQ-007 SHALL have port cmd_count  in  16  initial count, used by PROGRAM only.
REQ-008 SHALL have ports rsp_valid out 1 (one-cycle pulse), rsp_count out 16, rsp_status out 8 and rsp_err out 1.
REQ-009 SHALL have ports CS_N out 1, a out 2, dout out 8 (to 8254 data-in), din in 8 (from 8254 data-out), IOR_N out 1 and IOW_N out 1.

Function
REQ-010 SHALL assert cmd_ready only in state IDLE; a command is accepted on a clk edge where cmd_valid and cmd_ready are both 1.
REQ-011 SHALL run each bus access as SETUP, then STROBE, then HOLD, then GAP.
- SETUP, 1 cycle: CS_N=0, a/dout valid, both strobes 1.
- STROBE, STROBE_CYC cycles: IOW_N=0 for a write, IOR_N=0 for a read.
- HOLD, 1 cycle: both strobes 1, CS_N=0; read data is sampled from din here.
- GAP, 1 cycle: CS_N=1.
- Total: STROBE_CYC+3 cycles per access.
REQ-012 SHALL never assert IOR_N and IOW_N low in the same cycle, and SHALL hold a and dout constant from SETUP through HOLD.
REQ-013 SHALL start the first access in the cycle after acceptance and run the accesses of one command back-to-back; after the last GAP it SHALL spend one RESP cycle with rsp_valid=1, then return to IDLE.
REQ-014 PROGRAM SHALL perform the following writes:
- control word {2'b00,cmd_rw,cmd_mode,cmd_bcd} to a=11;
- then the count to a=00: rw=01 writes the low byte; rw=10 writes the high byte; rw=11 writes the low byte then the high byte.
REQ-015 On a successful PROGRAM, SHALL store cmd_rw into a shadow RW register and set a shadow-valid flag.
REQ-016 LATCH_READ SHALL perform the following accesses:
- write 8'h00 to a=11;
- then read a=00 per shadow RW: 01 reads low, 10 reads high, 11 reads low then high.
REQ-017 READBACK SHALL perform the following accesses:
- write 8'hC2 to a=11;
- read the status byte from a=00 into rsp_status;
- then read count bytes per shadow RW as in REQ-016.
REQ-018 Count assembly: bytes not read SHALL be 0, e.g. rw=01 gives {8'h00,low} and rw=10 gives {high,8'h00}; rsp_status SHALL be 8'h00 except for READBACK.
REQ-019 The following SHALL produce rsp_err=1 with zero bus accesses, with rsp_valid in the cycle after acceptance:
- cmd_op=11;
- PROGRAM with cmd_rw=00;
- LATCH_READ or READBACK while shadow-valid=0.
REQ-020 rsp_count/rsp_status/rsp_err SHALL hold their values from RESP until the next RESP.

Reset
REQ-021 Reset SHALL force the following, at any point including mid-access:
- state IDLE;
- CS_N=1, IOR_N=1, IOW_N=1, a=00, dout=8'h00;
- cmd_ready=0 while RST_N=0 and 1 from the first cycle after release;
- rsp_valid=0, rsp_count=0, rsp_status=0, rsp_err=0;
- shadow RW=00 and shadow-valid=0.
REQ-022 An aborted command SHALL produce no response, and partial read bytes SHALL be discarded.

Configuration
REQ-023 With S8254_SEQ_BCD_CHECK_EN defined, PROGRAM SHALL be rejected per REQ-019, leaving the shadow unchanged, if either condition holds:
- cmd_bcd=1 and any nibble of a byte to be written exceeds 9;
- cmd_mode[1:0]=11 and the count to be loaded equals 1.
REQ-024 Without S8254_SEQ_BCD_CHECK_EN, PROGRAM SHALL forward any count unchecked.

Verification
REQ-025 STROBE_CYC=2; PROGRAM mode=3, rw=11, bcd=0, count=16'h1234 -> writes 8'h36@11, 8'h34@00, 8'h12@00; each IOW_N low 2 cycles; rsp_valid 16 cycles after acceptance, rsp_err=0.
REQ-026 After REQ-025, LATCH_READ with din returning 8'h20 then 8'h01 -> write 8'h00@11, two reads @00, rsp_count=16'h0120.
REQ-027 After PROGRAM rw=01, READBACK with din 8'h96 then 8'h05 -> write 8'hC2@11, rsp_status=8'h96, rsp_count=16'h0005.
REQ-028 LATCH_READ straight after reset, or cmd_op=11 -> rsp_err=1 one cycle after acceptance, CS_N stays 1 throughout.
REQ-029 RST_N pulsed low during the STROBE of the second write -> IOW_N=1 and CS_N=1 asynchronously, no rsp_valid, next LATCH_READ errors.
REQ-030 With S8254_SEQ_BCD_CHECK_EN: PROGRAM bcd=1, rw=01, count=16'h001A -> rsp_err=1, no access; without the macro -> normal two writes.

Source files
------------

// File: rtl/s8254_seq_if.sv
// Command/response handshake and 8254 bus pins of the s8254_seq sequencer.
// slave = sequencer view, master = command source / bus-side view.
interface s8254_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_mode;
  logic [1:0]  cmd_rw;
  logic        cmd_bcd;
  logic [15:0] cmd_count;
  logic        rsp_valid;
  logic [15:0] rsp_count;
  logic [7:0]  rsp_status;
  logic        rsp_err;
  logic        CS_N;
  logic [1:0]  a;
  logic [7:0]  dout;
  logic [7:0]  din;
  logic        IOR_N;
  logic        IOW_N;

  modport slave (
    input  cmd_valid, cmd_op, cmd_mode, cmd_rw, cmd_bcd, cmd_count, din,
    output cmd_ready, rsp_valid, rsp_count, rsp_status, rsp_err,
           CS_N, a, dout, IOR_N, IOW_N
  );

  modport master (
    output cmd_valid, cmd_op, cmd_mode, cmd_rw, cmd_bcd, cmd_count, din,
    input  cmd_ready, rsp_valid, rsp_count, rsp_status, rsp_err,
           CS_N, a, dout, IOR_N, IOW_N
  );
endinterface

// File: rtl/s8254_seq.sv
// Command sequencer driving counter 0 of an 8254 over its 8-bit bus.
// Define S8254_SEQ_BCD_CHECK_EN to reject PROGRAM with bad BCD or mode-3 count of 1.
module s8254_seq #(
  parameter int unsigned STROBE_CYC = 2
) (
  input  logic        clk,
  input  logic        RST_N,
  s8254_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP, S_RESP
  } state_t;

  localparam logic [1:0] OP_PROG  = 2'b00;
  localparam logic [1:0] OP_LATCH = 2'b01;
  localparam logic [1:0] OP_RB    = 2'b10;

  state_t      state, state_nx;
  logic [3:0]  scnt;
  logic [1:0]  step, last_step;
  logic [1:0]  op_q, rw_q;
  logic [15:0] cnt_q;
  logic [7:0]  ctrl_q;
  logic [7:0]  rd_lo, rd_hi, rd_st;
  logic [15:0] rsp_count_q;
  logic [7:0]  rsp_status_q;
  logic        rsp_err_q;
  logic [1:0]  shadow_rw;
  logic        shadow_vld;

  logic        step_wr, step_hi, step_st;
  logic [1:0]  step_a;
  logic [7:0]  step_d;
  logic [1:0]  acc_rw;
  logic        acc_err, bcd_bad;

  // Step 0 is the control write, READBACK adds a status read, then 1 or 2 count bytes.
  assign last_step = 2'((op_q == OP_RB) ? 1 : 0) + ((rw_q == 2'b11) ? 2'd2 : 2'd1);

  always_comb begin
    step_wr = 1'b0;
    step_hi = 1'b0;
    step_st = 1'b0;
    step_a  = 2'b00;
    step_d  = '0;
    if (step == 2'd0) begin
      step_wr = 1'b1;
      step_a  = 2'b11;
      step_d  = ctrl_q;
    end else if (op_q == OP_RB && step == 2'd1) begin
      step_st = 1'b1;
    end else begin
      step_hi = (rw_q == 2'b10) || (rw_q == 2'b11 && step == last_step);
      step_wr = (op_q == OP_PROG);
      step_d  = step_hi ? cnt_q[15:8] : cnt_q[7:0];
    end
  end

`ifdef S8254_SEQ_BCD_CHECK_EN
  logic        lo_bad, hi_bad;
  logic [15:0] ld_cnt;
  always_comb begin
    lo_bad  = (bus.cmd_count[3:0] > 4'd9) || (bus.cmd_count[7:4] > 4'd9);
    hi_bad  = (bus.cmd_count[11:8] > 4'd9) || (bus.cmd_count[15:12] > 4'd9);
    ld_cnt  = bus.cmd_count;
    if (bus.cmd_rw == 2'b01) ld_cnt = {8'h00, bus.cmd_count[7:0]};
    if (bus.cmd_rw == 2'b10) ld_cnt = {bus.cmd_count[15:8], 8'h00};
    bcd_bad = (bus.cmd_bcd && ((bus.cmd_rw[0] && lo_bad) || (bus.cmd_rw[1] && hi_bad)))
           || (bus.cmd_mode[1:0] == 2'b11 && ld_cnt == 16'd1);
  end
`else
  assign bcd_bad = 1'b0;
`endif

  always_comb begin
    acc_rw  = (bus.cmd_op == OP_PROG) ? bus.cmd_rw : shadow_rw;
    acc_err = 1'b1;
    case (bus.cmd_op)
      OP_PROG:         acc_err = (bus.cmd_rw == 2'b00) || bcd_bad;
      OP_LATCH, OP_RB: acc_err = !shadow_vld;
      default:         acc_err = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (bus.cmd_valid) state_nx = acc_err ? S_RESP : S_SETUP;
      S_SETUP:  state_nx = S_STROBE;
      S_STROBE: if (scnt == 4'(STROBE_CYC - 1)) state_nx = S_HOLD;
      S_HOLD:   state_nx = S_GAP;
      S_GAP:    state_nx = (step == last_step) ? S_RESP : S_SETUP;
      S_RESP:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state        <= S_IDLE;
      scnt         <= '0;
      step         <= '0;
      op_q         <= '0;
      rw_q         <= '0;
      cnt_q        <= '0;
      ctrl_q       <= '0;
      rd_lo        <= '0;
      rd_hi        <= '0;
      rd_st        <= '0;
      rsp_count_q  <= '0;
      rsp_status_q <= '0;
      rsp_err_q    <= 1'b0;
      shadow_rw    <= '0;
      shadow_vld   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (bus.cmd_valid) begin
          op_q  <= bus.cmd_op;
          rw_q  <= acc_rw;
          cnt_q <= bus.cmd_count;
          step  <= '0;
          rd_lo <= '0;
          rd_hi <= '0;
          rd_st <= '0;
          case (bus.cmd_op)
            OP_PROG: ctrl_q <= {2'b00, bus.cmd_rw, bus.cmd_mode, bus.cmd_bcd};
            OP_RB:   ctrl_q <= 8'hC2;
            default: ctrl_q <= 8'h00;
          endcase
          if (acc_err) begin
            rsp_err_q    <= 1'b1;
            rsp_count_q  <= '0;
            rsp_status_q <= '0;
          end
        end
        S_SETUP:  scnt <= '0;
        S_STROBE: scnt <= scnt + 4'd1;
        S_HOLD: if (!step_wr) begin
          if (step_st)      rd_st <= bus.din;
          else if (step_hi) rd_hi <= bus.din;
          else              rd_lo <= bus.din;
        end
        S_GAP: begin
          if (step == last_step) begin
            rsp_err_q    <= 1'b0;
            rsp_count_q  <= {rd_hi, rd_lo};
            rsp_status_q <= rd_st;
            if (op_q == OP_PROG) begin
              shadow_rw  <= rw_q;
              shadow_vld <= 1'b1;
            end
          end else begin
            step <= step + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus pins decode straight from the state flop so reset releases them asynchronously.
  logic on_bus;
  assign on_bus         = (state == S_SETUP) || (state == S_STROBE) || (state == S_HOLD);
  assign bus.cmd_ready  = RST_N && (state == S_IDLE);
  assign bus.rsp_valid  = (state == S_RESP);
  assign bus.rsp_count  = rsp_count_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.CS_N       = !on_bus;
  assign bus.a          = (on_bus || state == S_GAP) ? step_a : 2'b00;
  assign bus.dout       = (on_bus || state == S_GAP) ? step_d : 8'h00;
  assign bus.IOW_N      = !(state == S_STROBE && step_wr);
  assign bus.IOR_N      = !(state == S_STROBE && !step_wr);

endmodule

// File: tb/tb_s8254_seq.sv
// Scoreboard bench for s8254_seq: expected bus accesses and responses are queued
// at stimulus time and checked by a monitor as the DUT produces them.
module tb_s8254_seq;
  localparam int unsigned SC = 2;

  logic clk = 1'b0;
  logic RST_N = 1'b0;
  s8254_seq_if bus ();

  s8254_seq #(.STROBE_CYC(SC)) dut (.clk(clk), .RST_N(RST_N), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [1:0]  a;
    logic [7:0]  d;
    int unsigned slen;
  } acc_t;

  typedef struct {
    bit          err;
    logic [15:0] cnt;
    logic [7:0]  st;
    int unsigned lat;
  } rsp_t;

  acc_t        exp_acc[$];
  rsp_t        exp_rsp[$];
  logic [7:0]  din_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_acc(bit wr, logic [1:0] a, logic [7:0] d);
    acc_t t;
    t.wr = wr; t.a = a; t.d = d; t.slen = SC;
    exp_acc.push_back(t);
  endtask

  task automatic push_rsp(bit err, logic [15:0] c, logic [7:0] s, int unsigned nacc);
    rsp_t t;
    t.err = err; t.cnt = c; t.st = s;
    t.lat = err ? 1 : 1 + nacc * (SC + 3);
    exp_rsp.push_back(t);
  endtask

  task automatic send(logic [1:0] op, logic [2:0] mode, logic [1:0] rw, logic bcd, logic [15:0] cnt);
    int unsigned k = 0;
    @(negedge clk);
    bus.cmd_op = op; bus.cmd_mode = mode; bus.cmd_rw = rw;
    bus.cmd_bcd = bcd; bus.cmd_count = cnt; bus.cmd_valid = 1'b1;
    while (bus.cmd_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k >= 50) begin
      n_bad++;
      $display("FAIL accept_timeout: cmd_ready=%b required 1 within 50 cycles", bus.cmd_ready);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned k = 0;
    while ((exp_rsp.size() != 0 || exp_acc.size() != 0) && k < 300) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Monitor: reconstructs each access between CS_N falling and rising, supplies read data.
  acc_t cur, e;
  rsp_t r;
  bit   in_acc = 0, rd_seen = 0, prev_rv = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!RST_N) begin
        in_acc = 0;
        prev_rv = 0;
        continue;
      end
      if (bus.CS_N === 1'b0) begin
        if (!in_acc) begin
          in_acc = 1; rd_seen = 0;
          cur.wr = 0; cur.a = bus.a; cur.d = bus.dout; cur.slen = 0;
        end else begin
          n_cmp++;
          if (bus.a !== cur.a || bus.dout !== cur.d) begin
            n_bad++;
            $display("FAIL addr_data_hold: a=%0h dout=%02h required a=%0h dout=%02h",
                     bus.a, bus.dout, cur.a, cur.d);
          end
        end
        n_cmp++;
        if (bus.IOR_N === 1'b0 && bus.IOW_N === 1'b0) begin
          n_bad++;
          $display("FAIL strobe_overlap: IOR_N=%b IOW_N=%b required not both 0", bus.IOR_N, bus.IOW_N);
        end
        if (bus.IOW_N === 1'b0) begin cur.wr = 1; cur.slen++; end
        if (bus.IOR_N === 1'b0) begin
          cur.slen++;
          if (!rd_seen) begin
            rd_seen = 1;
            bus.din = (din_q.size() != 0) ? din_q.pop_front() : 8'hEE;
          end
        end
      end else if (in_acc) begin
        in_acc = 0;
        n_cmp++;
        if (exp_acc.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_access: wr=%b a=%0h d=%02h required no access", cur.wr, cur.a, cur.d);
        end else begin
          e = exp_acc.pop_front();
          if (cur.wr !== e.wr || cur.a !== e.a || (e.wr && cur.d !== e.d) || cur.slen !== e.slen) begin
            n_bad++;
            $display("FAIL access: wr=%b a=%0h d=%02h strobe=%0d required wr=%b a=%0h d=%02h strobe=%0d",
                     cur.wr, cur.a, cur.d, cur.slen, e.wr, e.a, e.d, e.slen);
          end
        end
      end
      if (bus.rsp_valid === 1'b1) begin
        n_cmp++;
        if (prev_rv) begin
          n_bad++;
          $display("FAIL rsp_pulse: rsp_valid=1 for 2 cycles required 1-cycle pulse");
        end else if (exp_rsp.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_rsp: err=%b count=%04h required no response", bus.rsp_err, bus.rsp_count);
        end else begin
          r = exp_rsp.pop_front();
          if (bus.rsp_err !== r.err || bus.rsp_count !== r.cnt || bus.rsp_status !== r.st
              || (cyc - acc_cyc + 1) != r.lat) begin
            n_bad++;
            $display("FAIL response: err=%b count=%04h status=%02h lat=%0d required err=%b count=%04h status=%02h lat=%0d",
                     bus.rsp_err, bus.rsp_count, bus.rsp_status, cyc - acc_cyc + 1, r.err, r.cnt, r.st, r.lat);
          end
        end
      end
      prev_rv = (bus.rsp_valid === 1'b1);
    end
  end

  task automatic test_reset();
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_mode = 0; bus.cmd_rw = 0;
    bus.cmd_bcd = 0; bus.cmd_count = 0; bus.din = 8'h00;
    RST_N = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.cmd_ready, bus.CS_N, bus.IOR_N, bus.IOW_N} !== 4'b0111) begin
      n_bad++;
      $display("FAIL reset_ctrl: ready,cs,ior,iow=%b required 0111",
               {bus.cmd_ready, bus.CS_N, bus.IOR_N, bus.IOW_N});
    end
    n_cmp++;
    if (bus.a !== 2'b00 || bus.dout !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_bus: a=%0h dout=%02h required 0 00", bus.a, bus.dout);
    end
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_count, bus.rsp_status} !== 26'd0) begin
      n_bad++;
      $display("FAIL reset_rsp: valid=%b err=%b count=%04h status=%02h required all 0",
               bus.rsp_valid, bus.rsp_err, bus.rsp_count, bus.rsp_status);
    end
    RST_N = 1;
    @(negedge clk);
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_reset: cmd_ready=%b required 1", bus.cmd_ready);
    end
  endtask

  task automatic test_err_after_reset();
    push_rsp(1, 16'h0000, 8'h00, 0);
    send(2'b01, 3'd0, 2'b00, 1'b0, 16'h0000);
    wait_done();
    push_rsp(1, 16'h0000, 8'h00, 0);
    send(2'b11, 3'd0, 2'b11, 1'b0, 16'h0000);
    wait_done();
    n_cmp++;
    if (exp_rsp.size() != 0 || exp_acc.size() != 0 || bus.rsp_err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_cmds: pending rsp=%0d acc=%0d rsp_err=%b required 0 0 1",
               exp_rsp.size(), exp_acc.size(), bus.rsp_err);
    end
  endtask

  task automatic test_program();
    push_acc(1, 2'b11, 8'h36);
    push_acc(1, 2'b00, 8'h34);
    push_acc(1, 2'b00, 8'h12);
    push_rsp(0, 16'h0000, 8'h00, 3);
    send(2'b00, 3'd3, 2'b11, 1'b0, 16'h1234);
    wait_done();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_rsp.size() != 0 || exp_acc.size() != 0 || bus.rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL program: pending rsp=%0d acc=%0d rsp_err=%b required 0 0 0",
               exp_rsp.size(), exp_acc.size(), bus.rsp_err);
    end
  endtask

  task automatic test_latch_read();
    din_q.push_back(8'h20);
    din_q.push_back(8'h01);
    push_acc(1, 2'b11, 8'h00);
    push_acc(0, 2'b00, 8'h00);
    push_acc(0, 2'b00, 8'h00);
    push_rsp(0, 16'h0120, 8'h00, 3);
    send(2'b01, 3'd0, 2'b00, 1'b0, 16'h0000);
    wait_done();
    n_cmp++;
    if (exp_rsp.size() != 0 || exp_acc.size() != 0) begin
      n_bad++;
      $display("FAIL latch_read: pending rsp=%0d acc=%0d required 0 0", exp_rsp.size(), exp_acc.size());
    end
  endtask

  task automatic test_readback();
    push_acc(1, 2'b11, 8'h14);
    push_acc(1, 2'b00, 8'h77);
    push_rsp(0, 16'h0000, 8'h00, 2);
    send(2'b00, 3'd2, 2'b01, 1'b0, 16'h0077);
    wait_done();
    din_q.push_back(8'h96);
    din_q.push_back(8'h05);
    push_acc(1, 2'b11, 8'hC2);
    push_acc(0, 2'b00, 8'h00);
    push_acc(0, 2'b00, 8'h00);
    push_rsp(0, 16'h0005, 8'h96, 3);
    send(2'b10, 3'd0, 2'b00, 1'b0, 16'h0000);
    wait_done();
    repeat (4) @(negedge clk);
    n_cmp++;
    if (exp_rsp.size() != 0 || bus.rsp_count !== 16'h0005 || bus.rsp_status !== 8'h96) begin
      n_bad++;
      $display("FAIL readback_hold: pending=%0d count=%04h status=%02h required 0 0005 96",
               exp_rsp.size(), bus.rsp_count, bus.rsp_status);
    end
  endtask

  task automatic test_rw_high();
    push_acc(1, 2'b11, 8'h20);
    push_acc(1, 2'b00, 8'hAB);
    push_rsp(0, 16'h0000, 8'h00, 2);
    send(2'b00, 3'd0, 2'b10, 1'b0, 16'hAB00);
    wait_done();
    din_q.push_back(8'h5C);
    push_acc(1, 2'b11, 8'h00);
    push_acc(0, 2'b00, 8'h00);
    push_rsp(0, 16'h5C00, 8'h00, 2);
    send(2'b01, 3'd0, 2'b00, 1'b0, 16'h0000);
    wait_done();
    push_rsp(1, 16'h0000, 8'h00, 0);
    send(2'b00, 3'd0, 2'b00, 1'b0, 16'h1111);
    wait_done();
    n_cmp++;
    if (exp_rsp.size() != 0 || exp_acc.size() != 0) begin
      n_bad++;
      $display("FAIL rw_high: pending rsp=%0d acc=%0d required 0 0", exp_rsp.size(), exp_acc.size());
    end
  endtask

  task automatic test_bcd();
`ifdef S8254_SEQ_BCD_CHECK_EN
    push_rsp(1, 16'h0000, 8'h00, 0);
    send(2'b00, 3'd0, 2'b01, 1'b1, 16'h001A);
    wait_done();
    push_rsp(1, 16'h0000, 8'h00, 0);
    send(2'b00, 3'd3, 2'b01, 1'b0, 16'h0001);
    wait_done();
    din_q.push_back(8'h33);
    push_acc(1, 2'b11, 8'h00);
    push_acc(0, 2'b00, 8'h00);
    push_rsp(0, 16'h3300, 8'h00, 2);
`else
    push_acc(1, 2'b11, 8'h11);
    push_acc(1, 2'b00, 8'h1A);
    push_rsp(0, 16'h0000, 8'h00, 2);
    send(2'b00, 3'd0, 2'b01, 1'b1, 16'h001A);
    wait_done();
    din_q.push_back(8'h33);
    push_acc(1, 2'b11, 8'h00);
    push_acc(0, 2'b00, 8'h00);
    push_rsp(0, 16'h0033, 8'h00, 2);
`endif
    send(2'b01, 3'd0, 2'b00, 1'b0, 16'h0000);
    wait_done();
    n_cmp++;
    if (exp_rsp.size() != 0 || exp_acc.size() != 0) begin
      n_bad++;
      $display("FAIL bcd: pending rsp=%0d acc=%0d required 0 0", exp_rsp.size(), exp_acc.size());
    end
  endtask

  task automatic test_abort();
    push_acc(1, 2'b11, 8'h36);
    send(2'b00, 3'd3, 2'b11, 1'b0, 16'h1234);
    repeat (7) @(negedge clk);
    n_cmp++;
    if (bus.IOW_N !== 1'b0 || bus.a !== 2'b00 || bus.dout !== 8'h34) begin
      n_bad++;
      $display("FAIL abort_setup: IOW_N=%b a=%0h dout=%02h required 0 0 34", bus.IOW_N, bus.a, bus.dout);
    end
    RST_N = 0;
    #1;
    n_cmp++;
    if (bus.IOW_N !== 1'b1 || bus.CS_N !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_async: IOW_N=%b CS_N=%b rsp_valid=%b required 1 1 0",
               bus.IOW_N, bus.CS_N, bus.rsp_valid);
    end
    @(negedge clk);
    RST_N = 1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (exp_acc.size() != 0) begin
      n_bad++;
      $display("FAIL abort_first_write: pending acc=%0d required 0", exp_acc.size());
    end
    push_rsp(1, 16'h0000, 8'h00, 0);
    send(2'b01, 3'd0, 2'b00, 1'b0, 16'h0000);
    wait_done();
    n_cmp++;
    if (exp_rsp.size() != 0 || exp_acc.size() != 0) begin
      n_bad++;
      $display("FAIL abort_latch_err: pending rsp=%0d acc=%0d required 0 0", exp_rsp.size(), exp_acc.size());
    end
  endtask

  initial begin
    test_reset();
    test_err_after_reset();
    test_program();
    test_latch_read();
    test_readback();
    test_rw_high();
    test_bcd();
    test_abort();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached required completion");
    $fatal(1, "watchdog");
  end

endmodule
